// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: holds the cipher state and steps one external
// combinational round datapath per cycle, fetching round keys by index.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] round_key,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // state  | meaning
  // IDLE   | waiting for plaintext, in_ready high
  // WHITEN | initial AddRoundKey with key 0
  // ROUND  | one datapath round per valid key, rk_idx 1..NUM_ROUNDS
  // DONE   | ciphertext held on out_data until out_ready
  typedef enum logic [1:0] {IDLE, WHITEN, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  fsm_t         cur, nxt;
  logic [127:0] st_q, st_d;
  logic [3:0]   idx_q, idx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur   <= IDLE;
      st_q  <= '0;
      idx_q <= '0;
    end else begin
      cur   <= nxt;
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    nxt       = cur;
    st_d      = st_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_last   = 1'b0;
    case (cur)
      IDLE: begin
        // gated so in_ready reads low for the whole time reset is held
        in_ready = reset;
        if (in_valid && reset) begin
          st_d  = in_data;
          idx_d = '0;
          nxt   = WHITEN;
        end
      end
      WHITEN: begin
        if (rk_valid) begin
          st_d  = st_q ^ round_key;
          idx_d = 4'd1;
          nxt   = ROUND;
        end
      end
      ROUND: begin
        dp_last = (idx_q == LAST_IDX);
        if (rk_valid) begin
          st_d = dp_result;
          if (idx_q == LAST_IDX) nxt = DONE;
          else idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          nxt   = IDLE;
          idx_d = '0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy     = (cur != IDLE);
  assign rk_idx   = idx_q;
  assign dp_state = st_q;
  assign out_data = st_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: XOR stand-in and golden AES datapaths, a 10-round
// and a 14-round instance, scoreboard of expected ciphertexts.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         mode;     // 1: golden AES datapath on the 10-round instance
  logic         sel;      // 0: 10-round instance, 1: 14-round instance
  logic         in_valid, rk_en, out_ready;
  logic [127:0] in_data;

  logic         a_in_ready, a_dp_last, a_out_valid, a_busy;
  logic [3:0]   a_rk_idx;
  logic [127:0] a_round_key, a_dp_state, a_dp_result, a_out_data;
  logic         b_in_ready, b_dp_last, b_out_valid, b_busy;
  logic [3:0]   b_rk_idx;
  logic [127:0] b_round_key, b_dp_state, b_dp_result, b_out_data;

  logic [127:0] aes_rk [0:15];
  logic [127:0] sb_q [$];
  int checks = 0;
  int errors = 0;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_data(in_data), .rk_idx(a_rk_idx), .rk_valid(rk_en), .round_key(a_round_key),
    .dp_state(a_dp_state), .dp_last(a_dp_last), .dp_result(a_dp_result),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
    .busy(a_busy));

  aes_round_ctrl #(.NUM_ROUNDS(14)) dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_data(in_data), .rk_idx(b_rk_idx), .rk_valid(rk_en), .round_key(b_round_key),
    .dp_state(b_dp_state), .dp_last(b_dp_last), .dp_result(b_dp_result),
    .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
    .busy(b_busy));

  wire          v_in_ready  = sel ? b_in_ready  : a_in_ready;
  wire          v_dp_last   = sel ? b_dp_last   : a_dp_last;
  wire          v_out_valid = sel ? b_out_valid : a_out_valid;
  wire          v_busy      = sel ? b_busy      : a_busy;
  wire [3:0]    v_rk_idx    = sel ? b_rk_idx    : a_rk_idx;
  wire [127:0]  v_dp_state  = sel ? b_dp_state  : a_dp_state;
  wire [127:0]  v_out_data  = sel ? b_out_data  : a_out_data;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // multiplicative inverse as x^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] s [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) m[r+4*c] = s[r+4*c];
      end else begin
        m[4*c]   = xt(s[4*c]) ^ gmul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
        m[4*c+1] = s[4*c] ^ xt(s[4*c+1]) ^ gmul(s[4*c+2], 8'h03) ^ s[4*c+3];
        m[4*c+2] = s[4*c] ^ s[4*c+1] ^ xt(s[4*c+2]) ^ gmul(s[4*c+3], 8'h03);
        m[4*c+3] = gmul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ xt(s[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
    return o ^ rk;
  endfunction

  always_comb begin
    a_round_key = mode ? aes_rk[a_rk_idx] : {16{{4'h0, a_rk_idx}}};
    a_dp_result = mode ? aes_round(a_dp_state, a_round_key, a_dp_last) : (a_dp_state ^ a_round_key);
  end

  assign b_round_key = {16{{4'h0, b_rk_idx}}};
  assign b_dp_result = b_dp_state ^ b_round_key;

  task automatic build_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) aes_rk[r] = '0;
    for (int r = 0; r < 11; r++) aes_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1. Offers pt, optionally stalls keys at one
  // index, optionally holds out_ready low in DONE, then completes the handshake.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input int stall_at,
                           input int stall_len, input int hold, input int exp_lat, input int nr);
    int lat, stalled, last_cnt;
    logic [3:0]   last_idx, frz_idx;
    logic [127:0] frz_st, exp_o;
    bit was_stall;
    in_data  = pt;
    in_valid = 1'b1;
    chk("in_ready_idle", 128'(v_in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(exp);
    lat = 0; stalled = 0; last_cnt = 0; last_idx = '0;
    frz_idx = '0; frz_st = '0;
    while (!v_out_valid && lat < 200) begin
      if (v_dp_last) begin
        last_cnt++;
        last_idx = v_rk_idx;
      end
      was_stall = (int'(v_rk_idx) == stall_at) && (stalled < stall_len);
      rk_en = !was_stall;
      if (was_stall) begin
        stalled++;
        frz_idx = v_rk_idx;
        frz_st  = v_dp_state;
      end
      @(posedge clk); #1;
      lat++;
      if (was_stall) begin
        chk("stall_rk_idx", 128'(v_rk_idx), 128'(frz_idx));
        chk("stall_dp_state", v_dp_state, frz_st);
      end
    end
    rk_en = 1'b1;
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("dp_last_count", 128'(last_cnt), 128'd1);
    chk("dp_last_idx", 128'(last_idx), 128'(nr));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = ~pt;
      chk("hold_out_valid", 128'(v_out_valid), 128'd1);
      chk("hold_out_data", v_out_data, sb_q[0]);
      chk("hold_in_ready", 128'(v_in_ready), 128'd0);
      chk("hold_busy", 128'(v_busy), 128'd1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_o = sb_q.pop_front();
    chk("out_data", v_out_data, exp_o);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", 128'(v_out_valid), 128'd0);
    chk("post_in_ready", 128'(v_in_ready), 128'd1);
    chk("post_busy", 128'(v_busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; mode = 1'b0; sel = 1'b0;
    in_valid = 1'b0; rk_en = 1'b1; out_ready = 1'b0; in_data = '0;
    build_keys(128'h000102030405060708090a0b0c0d0e0f);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(v_out_valid), 128'd0);
    chk("rst_busy", 128'(v_busy), 128'd0);
    chk("rst_in_ready", 128'(v_in_ready), 128'd0);
    chk("rst_rk_idx", 128'(v_rk_idx), 128'd0);
    chk("rst_dp_last", 128'(v_dp_last), 128'd0);
    chk("rst_dp_state", v_dp_state, 128'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    run_block('0, {16{8'h0b}}, -1, 0, 0, 11, 10);
    run_block('0, {16{8'h0b}}, 5, 3, 0, 14, 10);
    run_block('0, {16{8'h0b}}, -1, 0, 5, 11, 10);
    run_block(128'h0123456789abcdeffedcba9876543210,
              128'h0123456789abcdeffedcba9876543210 ^ {16{8'h0b}}, -1, 0, 0, 11, 10);

    // abort mid-ROUND with an asynchronous reset
    in_data  = 128'hdeadbeef;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (v_rk_idx != 4'd6 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx6", 128'(v_rk_idx), 128'd6);
    #2 reset = 1'b0;
    #1;
    chk("abort_out_valid", 128'(v_out_valid), 128'd0);
    chk("abort_busy", 128'(v_busy), 128'd0);
    chk("abort_dp_last", 128'(v_dp_last), 128'd0);
    chk("abort_rk_idx", 128'(v_rk_idx), 128'd0);
    chk("abort_in_ready", 128'(v_in_ready), 128'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_block('0, {16{8'h0b}}, -1, 0, 0, 11, 10);

    mode = 1'b1;
    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, 0, 0, 11, 10);
    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 2, 0, 13, 10);
    mode = 1'b0;

    sel = 1'b1;
    run_block('0, {16{8'h0f}}, -1, 0, 0, 15, 14);
    run_block('0, {16{8'h0f}}, 9, 1, 2, 16, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
